// File: rtl/servo_pwm_monitor_pkg.sv
// Shared FSM encodings and counter helpers for the servo PWM monitor.
package servo_pwm_monitor_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int CNT_W = 32;

    localparam logic [CNT_W-1:0] CNT_ONE = 32'd1;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lim
    );
        return (v >= lim) ? lim : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with edge detection on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/servo_pwm_monitor.sv
// Measures servo pulse width and frame period; flags range errors and signal loss.
module servo_pwm_monitor
    import servo_pwm_monitor_pkg::*;
#(
    parameter int unsigned MIN_PW     = 100000,
    parameter int unsigned MAX_PW     = 200000,
    parameter int unsigned PERIOD_MAX = 2500000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SERVO_IN,
    output logic [31:0] PULSE_WIDTH,
    output logic [31:0] PERIOD,
    output logic        VALID,
    output logic        RANGE_ERR,
    output logic        LOS
);

    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PW);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_PW);
    localparam logic [CNT_W-1:0] P_MAX = CNT_W'(PERIOD_MAX);

    logic level;
    logic rise;
    logic fall;

    sync_edge u_sync (
        .clk   (CLK),
        .rst   (RESET),
        .din   (SERVO_IN),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic [CNT_W-1:0] prd_q, prd_d;
    logic             valid_q, valid_d;
    logic             rerr_q, rerr_d;
    logic             los_q, los_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_WAIT;
            hi_q    <= '0;
            per_q   <= '0;
            idle_q  <= '0;
            pw_q    <= '0;
            prd_q   <= '0;
            valid_q <= 1'b0;
            rerr_q  <= 1'b0;
            los_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            per_q   <= per_d;
            idle_q  <= idle_d;
            pw_q    <= pw_d;
            prd_q   <= prd_d;
            valid_q <= valid_d;
            rerr_q  <= rerr_d;
            los_q   <= los_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        per_d   = per_q;
        idle_d  = idle_q;
        pw_d    = pw_q;
        prd_d   = prd_q;
        valid_d = 1'b0;
        rerr_d  = rerr_q;
        los_d   = los_q;

        unique case (state_q)
            ST_WAIT: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    hi_d    = CNT_ONE;
                    per_d   = CNT_ONE;
                    idle_d  = '0;
                end else if (idle_q >= P_MAX) begin
                    los_d = 1'b1;
                end else begin
                    idle_d = sat_inc(idle_q, P_MAX);
                end
            end
            ST_HIGH: begin
                if (per_q >= P_MAX) begin
                    state_d = ST_WAIT;
                    los_d   = 1'b1;
                    hi_d    = '0;
                    per_d   = '0;
                end else begin
                    per_d = sat_inc(per_q, P_MAX);
                    if (fall) begin
                        state_d = ST_LOW;
                    end else if (level) begin
                        hi_d = sat_inc(hi_q, P_MAX);
                    end
                end
            end
            ST_LOW: begin
                // A rise closes the frame before any timeout check.
                if (rise) begin
                    pw_d    = hi_q;
                    prd_d   = per_q;
                    rerr_d  = (hi_q < MIN_W) | (hi_q > MAX_W);
                    valid_d = 1'b1;
                    los_d   = 1'b0;
                    hi_d    = CNT_ONE;
                    per_d   = CNT_ONE;
                    state_d = ST_HIGH;
                end else if (per_q >= P_MAX) begin
                    state_d = ST_WAIT;
                    los_d   = 1'b1;
                    hi_d    = '0;
                    per_d   = '0;
                end else begin
                    per_d = sat_inc(per_q, P_MAX);
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign PULSE_WIDTH = pw_q;
    assign PERIOD      = prd_q;
    assign VALID       = valid_q;
    assign RANGE_ERR   = rerr_q;
    assign LOS         = los_q;

endmodule

// File: tb/tb_servo_pwm_monitor.sv
// Directed bench for servo_pwm_monitor with MIN_PW=10, MAX_PW=20, PERIOD_MAX=100.
module tb_servo_pwm_monitor;

    logic        CLK;
    logic        RESET;
    logic        SERVO_IN;
    logic [31:0] PULSE_WIDTH;
    logic [31:0] PERIOD;
    logic        VALID;
    logic        RANGE_ERR;
    logic        LOS;

    servo_pwm_monitor #(
        .MIN_PW     (10),
        .MAX_PW     (20),
        .PERIOD_MAX (100)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SERVO_IN    (SERVO_IN),
        .PULSE_WIDTH (PULSE_WIDTH),
        .PERIOD      (PERIOD),
        .VALID       (VALID),
        .RANGE_ERR   (RANGE_ERR),
        .LOS         (LOS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int h;
        int l;
        int n;
        int pw;
        int per;
        int rerr;
    } vec_t;

    vec_t vt[8];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int vcnt     = 0;
    int last_vcyc = 0;
    int prev_vcyc = 0;
    logic [31:0] cap_pw;
    logic [31:0] cap_per;
    logic        cap_rerr;
    logic        cap_los;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (VALID === 1'b1) begin
            vcnt++;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
            cap_pw    = PULSE_WIDTH;
            cap_per   = PERIOD;
            cap_rerr  = RANGE_ERR;
            cap_los   = LOS;
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            SERVO_IN = v;
            tick();
        end
    endtask

    task automatic frame(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        SERVO_IN = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int v0;
        int lat;
        logic l102;
        logic l103;

        vt[0] = '{15, 85, 3, 15, 100, 0};
        vt[1] = '{5, 60, 2, 5, 65, 1};
        vt[2] = '{25, 60, 2, 25, 85, 1};
        vt[3] = '{1, 39, 2, 1, 40, 1};
        vt[4] = '{10, 30, 1, 10, 40, 0};
        vt[5] = '{20, 30, 1, 20, 50, 0};
        vt[6] = '{9, 30, 1, 9, 39, 1};
        vt[7] = '{21, 30, 1, 21, 51, 1};

        RESET    = 1'b1;
        SERVO_IN = 1'b0;

        // Reset state
        do_reset();
        check("rst_pw", PULSE_WIDTH, 0);
        check("rst_per", PERIOD, 0);
        check("rst_valid", VALID, 0);
        check("rst_rerr", RANGE_ERR, 0);
        check("rst_los", LOS, 0);

        // Table: n frames then one trailing rise; first rise only arms.
        for (int k = 0; k < 8; k++) begin
            do_reset();
            drive(1'b0, 2);
            v0 = vcnt;
            for (int f = 0; f < vt[k].n; f++) frame(vt[k].h, vt[k].l);
            lat = 0;
            for (int t = 1; t <= 5; t++) begin
                SERVO_IN = 1'b1;
                tick();
                if (VALID === 1'b1 && lat == 0) lat = t;
            end
            check($sformatf("v%0d_count", k), vcnt - v0, vt[k].n);
            check($sformatf("v%0d_pw", k), cap_pw, vt[k].pw);
            check($sformatf("v%0d_per", k), cap_per, vt[k].per);
            check($sformatf("v%0d_rerr", k), cap_rerr, vt[k].rerr);
            check($sformatf("v%0d_los", k), cap_los, 0);
            check($sformatf("v%0d_latency", k), lat, 3);
            if (vt[k].n >= 2)
                check($sformatf("v%0d_interval", k),
                      last_vcyc - prev_vcyc, vt[k].h + vt[k].l);
        end

        // Line held low after valid frames
        do_reset();
        drive(1'b0, 2);
        v0 = vcnt;
        frame(15, 85);
        frame(15, 85);
        l102 = 1'b0;
        l103 = 1'b0;
        for (int t = 1; t <= 103; t++) begin
            SERVO_IN = (t <= 15);
            tick();
            if (t == 3) begin
                check("low_pub_count", vcnt - v0, 2);
                v0 = vcnt;
            end
            if (t == 102) l102 = LOS;
            if (t == 103) l103 = LOS;
        end
        check("low_los_before", l102, 0);
        check("low_los_at", l103, 1);
        check("low_no_valid", vcnt - v0, 0);
        check("low_hold_pw", PULSE_WIDTH, 15);
        check("low_hold_per", PERIOD, 100);
        drive(1'b0, 20);
        v0 = vcnt;
        frame(15, 85);
        check("resume_arm_only", vcnt - v0, 0);
        check("resume_los_held", LOS, 1);
        drive(1'b1, 2);
        check("resume_valid_early", VALID, 0);
        drive(1'b1, 1);
        check("resume_valid", VALID, 1);
        check("resume_los_clr", LOS, 0);
        check("resume_pw", PULSE_WIDTH, 15);

        // Line stuck high for 150 cycles
        do_reset();
        drive(1'b0, 2);
        frame(15, 85);
        drive(1'b1, 3);
        v0 = vcnt;
        check("stuck_pw_pre", PULSE_WIDTH, 15);
        drive(1'b1, 147);
        check("stuck_los", LOS, 1);
        check("stuck_no_valid", vcnt - v0, 0);
        drive(1'b0, 10);
        drive(1'b1, 5);
        check("stuck_wait_rearm", vcnt - v0, 0);
        check("stuck_hold_pw", PULSE_WIDTH, 15);
        drive(1'b1, 10);
        drive(1'b0, 85);
        drive(1'b1, 3);
        check("stuck_recover", vcnt - v0, 1);
        check("stuck_rec_per", PERIOD, 100);
        check("stuck_rec_los", LOS, 0);

        // Reset pulse in the middle of a high phase
        do_reset();
        drive(1'b0, 2);
        frame(5, 60);
        drive(1'b1, 3);
        check("mid_pre_rerr", RANGE_ERR, 1);
        drive(1'b1, 4);
        RESET    = 1'b1;
        SERVO_IN = 1'b1;
        tick();
        check("mid_pw", PULSE_WIDTH, 0);
        check("mid_per", PERIOD, 0);
        check("mid_valid", VALID, 0);
        check("mid_rerr", RANGE_ERR, 0);
        check("mid_los", LOS, 0);
        RESET = 1'b0;
        drive(1'b0, 5);
        v0 = vcnt;
        frame(15, 85);
        check("mid_arm_only", vcnt - v0, 0);
        drive(1'b1, 3);
        check("mid_first_pub", vcnt - v0, 1);
        check("mid_pub_pw", PULSE_WIDTH, 15);
        check("mid_pub_per", PERIOD, 100);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
